// File: rtl/pimp_pkg.sv
// Shared PIMP definitions: run-controller state encoding and the halt instruction.
// No latency or backpressure: constants and types only.
// The core's Control decoder uses the same HALT_INSTR value.
package pimp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        NEXT,
        DONE
    } seq_state_t;

    localparam logic [8:0] HALT_INSTR = 9'h1FF;

endpackage

// File: rtl/cycle_counter.sv
// Per-program cycle counter with clear, enable and saturation, plus timeout compare.
// Latency: count updates one edge after en; hit is combinational from count.
// No backpressure: free-running whenever enabled.
module cycle_counter #(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(50000)
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             hit
);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count == TIMEOUT);

endmodule

// File: rtl/prog_sequencer.sv
// Run controller: parks the core, launches NUM_PROG programs per Go, reports per-program cycle counts.
// Latency: Go -> LAUNCH next edge; halt in RUN cycle k -> ResultValid in the following cycle; 2-cycle gap between programs.
// No backpressure: Go is a level sampled in IDLE/DONE only; results are one-cycle pulses held until the next one.
module prog_sequencer #(
    parameter int               NUM_PROG = 3,
    parameter int               ADDR_W   = 8,
    parameter int               CNT_W    = 16,
    parameter logic [CNT_W-1:0] TIMEOUT  = CNT_W'(50000)
) (
    input  logic                       CLK,
    input  logic                       RST_n,
    input  logic                       Go,
    input  logic [NUM_PROG*ADDR_W-1:0] ProgAddr,
    input  logic [8:0]                 InstrOut,
    output logic                       Start,
    output logic [ADDR_W-1:0]          StartAddr,
    output logic                       Busy,
    output logic                       Done,
    output logic [1:0]                 ProgIdx,
    output logic                       ResultValid,
    output logic [1:0]                 ResultIdx,
    output logic [CNT_W-1:0]           ResultCount,
    output logic                       ResultTimeout
);

    import pimp_pkg::*;

    seq_state_t        state;
    logic [1:0]        idx;
    logic              startQ;
    logic [ADDR_W-1:0] addrQ;
    logic [CNT_W-1:0]  count;
    logic              hit;
    logic              cntClr;
    logic              cntEn;
    logic              isHalt;
    logic              lastProg;

    function automatic logic [ADDR_W-1:0] addrOf(input logic [1:0] i);
        return ProgAddr[int'(i)*ADDR_W +: ADDR_W];
    endfunction

    // LAUNCH already counts so that RUN cycle k sees count == k.
    assign cntEn    = (state == LAUNCH) || (state == RUN);
    assign cntClr   = !cntEn;
    assign isHalt   = (InstrOut == HALT_INSTR);
    assign lastProg = (idx == 2'(NUM_PROG-1));

    cycle_counter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_cnt (
        .CLK   (CLK),
        .RST_n (RST_n),
        .clr   (cntClr),
        .en    (cntEn),
        .count (count),
        .hit   (hit)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state         <= IDLE;
            idx           <= 2'd0;
            startQ        <= 1'b1;
            addrQ         <= '0;
            Busy          <= 1'b0;
            Done          <= 1'b0;
            ResultValid   <= 1'b0;
            ResultIdx     <= 2'd0;
            ResultCount   <= '0;
            ResultTimeout <= 1'b0;
        end else begin
            ResultValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (Go) begin
                        state <= LAUNCH;
                        idx   <= 2'd0;
                        addrQ <= addrOf(2'd0);
                        Busy  <= 1'b1;
                    end
                end
                LAUNCH: begin
                    state  <= RUN;
                    startQ <= 1'b0;
                end
                RUN: begin
                    // Halt takes priority over a simultaneous timeout.
                    if (isHalt || hit) begin
                        state         <= NEXT;
                        startQ        <= 1'b1;
                        ResultValid   <= 1'b1;
                        ResultIdx     <= idx;
                        ResultCount   <= count;
                        ResultTimeout <= !isHalt;
                    end
                end
                NEXT: begin
                    if (lastProg) begin
                        state <= DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end else begin
                        state <= LAUNCH;
                        idx   <= idx + 2'd1;
                        addrQ <= addrOf(idx + 2'd1);
                    end
                end
                DONE: begin
                    if (!Go) begin
                        state <= IDLE;
                        Done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Start     = startQ;
    assign StartAddr = (state == IDLE) ? addrOf(2'd0) : addrQ;
    assign ProgIdx   = idx;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer with a linear-ROM core model and a result scoreboard.
module tb_prog_sequencer;

    localparam int          NP = 3;
    localparam int          AW = 8;
    localparam int          CW = 16;
    localparam logic [15:0] TO = 16'd10;
    localparam logic [8:0]  HALT = 9'h1FF;

    logic          CLK = 1'b0;
    logic          RST_n = 1'b0;
    logic          Go = 1'b0;
    logic [23:0]   ProgAddr = 24'd0;
    logic [8:0]    InstrOut;
    logic          Start;
    logic [7:0]    StartAddr;
    logic          Busy;
    logic          Done;
    logic [1:0]    ProgIdx;
    logic          ResultValid;
    logic [1:0]    ResultIdx;
    logic [15:0]   ResultCount;
    logic          ResultTimeout;

    always #5 CLK = ~CLK;

    prog_sequencer #(
        .NUM_PROG (NP),
        .ADDR_W   (AW),
        .CNT_W    (CW),
        .TIMEOUT  (TO)
    ) dut (
        .CLK           (CLK),
        .RST_n         (RST_n),
        .Go            (Go),
        .ProgAddr      (ProgAddr),
        .InstrOut      (InstrOut),
        .Start         (Start),
        .StartAddr     (StartAddr),
        .Busy          (Busy),
        .Done          (Done),
        .ProgIdx       (ProgIdx),
        .ResultValid   (ResultValid),
        .ResultIdx     (ResultIdx),
        .ResultCount   (ResultCount),
        .ResultTimeout (ResultTimeout)
    );

    // Core model: PC loads StartAddr while Start is high, otherwise steps linearly.
    logic [7:0] pc = 8'd0;
    logic [8:0] rom [256];
    always @(posedge CLK) pc <= Start ? StartAddr : pc + 8'd1;
    assign InstrOut = rom[pc];

    typedef struct {
        logic [1:0]  idx;
        logic [15:0] cnt;
        logic        to;
    } res_t;

    res_t expQ[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   lastPulseCyc = 0;
    int   runCnt = 0;
    int   lastRun = 0;
    logic prevStart = 1'b1;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic loadRom(input logic [7:0] h0, input logic [7:0] h1, input logic [7:0] h2, input bit useHalt);
        for (int a = 0; a < 256; a++) rom[a] = 9'(a);
        if (useHalt) begin
            rom[h0] = HALT;
            rom[h1] = HALT;
            rom[h2] = HALT;
        end
    endtask

    task automatic pushExp(input logic [1:0] i, input logic [15:0] c, input logic t);
        res_t e;
        e.idx = i;
        e.cnt = c;
        e.to  = t;
        expQ.push_back(e);
    endtask

    task automatic waitDone(input int lim);
        int n;
        n = 0;
        while (!Done && n < lim) begin
            @(negedge CLK);
            n++;
        end
        check("done_reached", 32'(Done), 32'd1);
    endtask

    task automatic pulseGo();
        @(negedge CLK);
        Go = 1'b1;
        @(negedge CLK);
        Go = 1'b0;
    endtask

    // Monitor: measures Start-low run length and scores every result pulse.
    always @(negedge CLK) begin
        res_t e;
        if (!RST_n) begin
            runCnt    = 0;
            prevStart = 1'b1;
        end else begin
            if (!Start) runCnt++;
            else if (!prevStart) begin
                lastRun = runCnt;
                runCnt  = 0;
            end
            prevStart = Start;
            if (ResultValid) begin
                lastPulseCyc = cyc;
                if (expQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got idx %0d count %0d, expected no result", ResultIdx, ResultCount);
                end else begin
                    e = expQ.pop_front();
                    check("result_idx", 32'(ResultIdx), 32'(e.idx));
                    check("result_count", 32'(ResultCount), 32'(e.cnt));
                    check("result_timeout", 32'(ResultTimeout), 32'(e.to));
                    check("start_low_cycles", 32'(lastRun), 32'(e.cnt));
                end
            end
        end
    end

    initial begin
        bit bad;

        // Reset state
        ProgAddr = {8'd40, 8'd20, 8'd0};
        loadRom(8'd4, 8'd24, 8'd44, 1'b1);
        #12;
        check("rst_start", 32'(Start), 32'd1);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_count", 32'(ResultCount), 32'd0);
        check("rst_valid", 32'(ResultValid), 32'd0);
        check("rst_progidx", 32'(ProgIdx), 32'd0);
        @(negedge CLK);
        RST_n = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            if (Start !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0 || ResultValid !== 1'b0 || ResultCount !== 16'd0) bad = 1'b1;
        end
        check("idle_hold", 32'(bad), 32'd0);
        ProgAddr[7:0] = 8'd7;
        #1;
        check("idle_startaddr_comb", 32'(StartAddr), 32'd7);
        ProgAddr[7:0] = 8'd0;

        // Three halting programs, 5 cycles each
        for (int i = 0; i < 3; i++) pushExp(2'(i), 16'd5, 1'b0);
        pulseGo();
        check("launch_busy", 32'(Busy), 32'd1);
        check("launch_start", 32'(Start), 32'd1);
        @(negedge CLK);
        check("run_start_low", 32'(Start), 32'd0);
        waitDone(200);
        check("done_after_pulse", 32'(cyc - lastPulseCyc), 32'd1);
        check("haltA_queue_empty", 32'(expQ.size()), 32'd0);
        @(negedge CLK);
        check("back_to_idle", 32'(Done), 32'd0);

        // No halt: every program times out
        ProgAddr = {8'd100, 8'd80, 8'd60};
        loadRom(8'd0, 8'd0, 8'd0, 1'b0);
        for (int i = 0; i < 3; i++) pushExp(2'(i), TO, 1'b1);
        pulseGo();
        waitDone(200);
        check("timeout_queue_empty", 32'(expQ.size()), 32'd0);
        @(negedge CLK);

        // Halt coincides with timeout on program 0; Go held through DONE
        ProgAddr = {8'd150, 8'd130, 8'd110};
        loadRom(8'd119, 8'd132, 8'd152, 1'b1);
        pushExp(2'd0, TO, 1'b0);
        pushExp(2'd1, 16'd3, 1'b0);
        pushExp(2'd2, 16'd3, 1'b0);
        @(negedge CLK);
        Go = 1'b1;
        waitDone(200);
        bad = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            if (Done !== 1'b1 || Busy !== 1'b0 || Start !== 1'b1) bad = 1'b1;
        end
        check("done_hold_go", 32'(bad), 32'd0);
        check("tie_queue_empty", 32'(expQ.size()), 32'd0);
        Go = 1'b0;
        @(negedge CLK);
        check("drop_go_idle", 32'(Done), 32'd0);
        check("drop_go_startaddr", 32'(StartAddr), 32'd110);
        pushExp(2'd0, TO, 1'b0);
        pushExp(2'd1, 16'd3, 1'b0);
        pushExp(2'd2, 16'd3, 1'b0);
        Go = 1'b1;
        @(negedge CLK);
        Go = 1'b0;
        check("relaunch_idx", 32'(ProgIdx), 32'd0);
        check("relaunch_busy", 32'(Busy), 32'd1);
        waitDone(200);
        check("relaunch_queue_empty", 32'(expQ.size()), 32'd0);
        @(negedge CLK);

        // Asynchronous reset during program 1
        ProgAddr = {8'd200, 8'd180, 8'd160};
        loadRom(8'd0, 8'd0, 8'd0, 1'b0);
        pushExp(2'd0, TO, 1'b1);
        pulseGo();
        begin
            int n;
            n = 0;
            while (!(ProgIdx == 2'd1 && Start == 1'b0) && n < 100) begin
                @(negedge CLK);
                n++;
            end
        end
        check("reached_prog1_run", 32'(ProgIdx == 2'd1 && Start == 1'b0), 32'd1);
        repeat (3) @(negedge CLK);
        #1;
        RST_n = 1'b0;
        #1;
        check("arst_start", 32'(Start), 32'd1);
        check("arst_busy", 32'(Busy), 32'd0);
        check("arst_progidx", 32'(ProgIdx), 32'd0);
        check("arst_count", 32'(ResultCount), 32'd0);
        repeat (3) @(negedge CLK);
        RST_n = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            if (Busy !== 1'b0 || Done !== 1'b0 || ResultValid !== 1'b0 || Start !== 1'b1) bad = 1'b1;
        end
        check("post_arst_idle", 32'(bad), 32'd0);
        check("arst_queue_empty", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
